// File: rtl/w0rm_core_pkg.sv
// Shared definitions for the w0rm core: FSM state encoding and the address-width helper
// used by the register file, its sweep reader and their benches.
package w0rm_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ceil(log2(n)), floored at 1 so a single-register file still gets a 1-bit address
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/w0rm_util_stream_reg.sv
// One-entry valid/ready holding register. The producer may load only when load_ok is high;
// the held word stays put while the consumer stalls.
module w0rm_util_stream_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_load_ok
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_load_ok = !r_valid || i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/w0rm_core_regfile_dump.sv
// Sweeps every register through one combinational read port and streams {addr, data}
// beats over valid/ready; pulses done once the final beat is taken.
module w0rm_core_regfile_dump
  import w0rm_core_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int NUM_REGISTERS = 4,
  localparam int ADDR_WIDTH    = log2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] port_read_addr,
  input  logic [DATA_WIDTH-1:0] port_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGISTERS - 1);

  state_t                          r_state;
  logic [ADDR_WIDTH-1:0]           r_cnt;
  logic                            r_busy;
  logic                            r_done;
  logic                            w_load_ok;
  logic                            w_load;
  logic                            w_valid;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_beat;

  // Capturing port_read_data in the load cycle is what gives each beat its snapshot value
  assign w_load         = (r_state == ST_READ) && w_load_ok;
  assign port_read_addr = (r_state == ST_READ) ? r_cnt : '0;
  assign busy           = r_busy;
  assign done           = r_done;
  assign out_valid      = w_valid;
  assign out_addr       = w_beat[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign out_data       = w_beat[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_READ;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          // Counter stops at the last index rather than wrapping
          if (w_load) begin
            if (r_cnt == LAST) r_state <= ST_DRAIN;
            else               r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_valid && out_ready) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  w0rm_util_stream_reg #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_data   ({r_cnt, port_read_data}),
    .i_ready  (out_ready),
    .o_valid  (w_valid),
    .o_data   (w_beat),
    .o_load_ok(w_load_ok)
  );

endmodule

// File: tb/tb_w0rm_core_regfile_dump.sv
// Scoreboard bench: stimulus pushes expected {addr,data} beats, monitors pop and compare on
// each accepted beat. A 4-entry and a 5-entry instance are exercised.
module tb_w0rm_core_regfile_dump;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int pass  = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  // ---------------- 4-register instance with forwarding regfile model
  logic       start4 = 1'b0, ready4 = 1'b1, busy4, done4, valid4;
  logic [1:0] raddr4, addr4;
  logic [7:0] rdata4, data4;
  logic       we4 = 1'b0;
  logic [1:0] waddr4 = '0;
  logic [7:0] wdata4 = '0;
  logic [7:0] regs4 [4];

  always @(posedge clk) if (we4) regs4[waddr4] <= wdata4;
  assign rdata4 = (we4 && waddr4 == raddr4) ? wdata4 : regs4[raddr4];

  w0rm_core_regfile_dump #(.DATA_WIDTH(8), .NUM_REGISTERS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .busy(busy4), .done(done4),
    .port_read_addr(raddr4), .port_read_data(rdata4), .out_valid(valid4),
    .out_ready(ready4), .out_addr(addr4), .out_data(data4)
  );

  // ---------------- 5-register instance, regfile holds 0xA0 + index
  logic       start5 = 1'b0, ready5 = 1'b1, busy5, done5, valid5;
  logic [2:0] raddr5, addr5;
  logic [7:0] rdata5, data5;
  assign rdata5 = 8'hA0 + {5'd0, raddr5};

  w0rm_core_regfile_dump #(.DATA_WIDTH(8), .NUM_REGISTERS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .busy(busy5), .done(done5),
    .port_read_addr(raddr5), .port_read_data(rdata5), .out_valid(valid5),
    .out_ready(ready5), .out_addr(addr5), .out_data(data5)
  );

  // ---------------- scoreboards and monitors
  logic [15:0] q4[$];
  logic [15:0] q5[$];
  int acc4 = 0, dn4 = 0, acc5 = 0, dn5 = 0, bad5 = 0;
  logic        held4 = 1'b0;
  logic [15:0] hv4 = '0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (valid4 && held4) chk("hold4", {6'd0, addr4, data4}, hv4);
    held4 = valid4 && !ready4;
    hv4   = {6'd0, addr4, data4};
    if (valid4 && ready4) begin
      acc4++;
      if (q4.size() == 0) chk("beat4_extra", 1, 0);
      else begin
        e = q4.pop_front();
        chk("beat4_addr", addr4, e[15:8]);
        chk("beat4_data", data4, e[7:0]);
      end
    end
    if (done4) begin
      dn4++;
      chk("done4_busy", busy4, 0);
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (busy5 && raddr5 > 3'd4) bad5++;
    if (valid5 && ready5) begin
      acc5++;
      if (q5.size() == 0) chk("beat5_extra", 1, 0);
      else begin
        e = q5.pop_front();
        chk("beat5_addr", addr5, e[15:8]);
        chk("beat5_data", data5, e[7:0]);
      end
    end
    if (done5) dn5++;
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input logic [1:0] a, input logic [7:0] d);
    we4 = 1'b1; waddr4 = a; wdata4 = d;
    tick();
    we4 = 1'b0;
  endtask

  task automatic push_std4();
    q4.push_back(16'h0011); q4.push_back(16'h0122);
    q4.push_back(16'h0233); q4.push_back(16'h0344);
  endtask

  task automatic wait_done4(input int n, input string nm);
    int i;
    i = 0;
    while (!done4 && i < n) begin tick(); i++; end
    chk(nm, done4, 1);
  endtask

  int a0, d0;
  bit bp [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

  initial begin
    // preload while the DUTs are held in reset
    wr4(0, 8'h11); wr4(1, 8'h22); wr4(2, 8'h33); wr4(3, 8'h44);
    chk("rst_valid", valid4, 0); chk("rst_busy", busy4, 0); chk("rst_done", done4, 0);
    chk("rst_addr", addr4, 0);   chk("rst_data", data4, 0); chk("rst_raddr", raddr4, 0);
    reset_n = 1'b1;
    tick();

    // free-running consumer
    push_std4();
    start4 = 1'b1; tick(); start4 = 1'b0;          // edge N
    chk("t1_busy", busy4, 1); chk("t1_v_early", valid4, 0);
    tick();                                         // N+1
    chk("t1_v0", valid4, 1); chk("t1_a0", addr4, 0);
    tick(); tick(); tick();                         // N+4
    chk("t1_a3", addr4, 3); chk("t1_nodone", done4, 0);
    tick();                                         // N+5
    chk("t1_done", done4, 1); chk("t1_busy_lo", busy4, 0); chk("t1_v_lo", valid4, 0);
    tick();
    chk("t1_done_pulse", done4, 0);

    // backpressure: 3 stalled cycles push done to N+8
    push_std4();
    d0 = dn4;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready4 = bp[i];
      tick();
      if (i < 7) chk("t2_early_done", done4, 0);
    end
    chk("t2_done", done4, 1);
    ready4 = 1'b1;
    tick();
    chk("t2_done_cnt", dn4 - d0, 1);

    // start while busy is ignored; start in the done cycle is accepted
    push_std4();
    a0 = acc4; d0 = dn4;
    start4 = 1'b1; tick(); start4 = 1'b0;          // N
    tick();                                         // N+1
    start4 = 1'b1; tick(); start4 = 1'b0;          // N+2
    tick(); tick(); tick();                         // N+5
    chk("t3_done", done4, 1);
    push_std4();
    start4 = 1'b1; tick(); start4 = 1'b0;
    chk("t3_restart_busy", busy4, 1);
    chk("t3_beats", acc4 - a0, 4);
    chk("t3_dones", dn4 - d0, 1);
    wait_done4(20, "t3_second_done");
    tick();
    chk("t3_beats2", acc4 - a0, 8);

    // concurrent writes: reg1 written while beat1 held, reg2 written in beat2's load cycle
    q4.push_back(16'h0011); q4.push_back(16'h0122);
    q4.push_back(16'h0299); q4.push_back(16'h0344);
    start4 = 1'b1; tick(); start4 = 1'b0;          // N
    tick(); tick();                                 // N+2, beat1 loaded
    ready4 = 1'b0; we4 = 1'b1; waddr4 = 2'd1; wdata4 = 8'h77;
    tick();                                         // N+3, beat1 stalled
    ready4 = 1'b1; waddr4 = 2'd2; wdata4 = 8'h99;
    tick();                                         // N+4, beat2 loaded
    we4 = 1'b0;
    wait_done4(20, "t4_done");
    tick();
    wr4(1, 8'h22); wr4(2, 8'h33);

    // non-power-of-two register count
    for (int i = 0; i < 5; i++) q5.push_back({8'(i), 8'hA0 + 8'(i)});
    start5 = 1'b1; tick(); start5 = 1'b0;
    tick(); tick(); tick(); tick(); tick();         // N+5
    chk("t5_a4", addr5, 4); chk("t5_nodone", done5, 0);
    tick();                                         // N+6
    chk("t5_done", done5, 1);
    tick();
    chk("t5_beats", acc5, 5); chk("t5_range", bad5, 0);

    // reset while beat1 is valid
    push_std4();
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick(); tick();                                 // beat1 valid
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", valid4, 0); chk("t6_busy", busy4, 0);
    chk("t6_addr", addr4, 0);   chk("t6_data", data4, 0); chk("t6_raddr", raddr4, 0);
    q4.delete();
    d0 = dn4;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_nodone", dn4 - d0, 0);
    chk("t6_idle", busy4, 0);
    push_std4();
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick();
    chk("t6_restart_a0", addr4, 0);
    wait_done4(20, "t6_done");
    tick(); tick();

    chk("q4_empty", q4.size(), 0);
    chk("q5_empty", q5.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/w0rm_core_regfile_dump.md
# w0rm_core_regfile_dump

Sequential register-file reader that sweeps every register of a W0RM_Core_RegisterFile through one read port and streams each entry out as an {address, data} beat over a valid/ready handshake. It is the reading counterpart of the register-file write path. It sits beside the register file on a spare read port and feeds debug/trace logic or a file-compare consumer. It pulses done when the final beat has been accepted.

## Interface
- DATA_WIDTH, 8, register width in bits.
- NUM_REGISTERS, 4, number of registers swept (addresses 0..NUM_REGISTERS-1).
- ADDR_WIDTH (localparam), ceil(log2(NUM_REGISTERS)), address width, same rule as the register file.
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last beat is accepted.
- port_read_addr  out  ADDR_WIDTH  address to the register file read port.
- port_read_data  in  DATA_WIDTH  combinational read data (register file built SINGLE_CYCLE=1).
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts the beat when high with out_valid.
- out_addr  out  ADDR_WIDTH  register index of the beat.
- out_data  out  DATA_WIDTH  register contents of the beat.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - start=1 → READ, address counter cleared to 0.
  - start is ignored in READ and DRAIN, with no queuing.
- READ:
  - port_read_addr = counter.
  - When the output slot is free (!out_valid | out_ready), port_read_data and the counter are loaded into out_data/out_addr, out_valid=1, and the counter increments.
  - Loading counter = NUM_REGISTERS-1 → DRAIN. The counter never wraps or passes NUM_REGISTERS-1, including when NUM_REGISTERS is not a power of two.
- DRAIN: when out_valid & out_ready → out_valid=0, done=1 for one cycle, state IDLE.
- Output stability: while out_valid=1 and out_ready=0, out_addr and out_data hold. No beat is duplicated or dropped.
- Snapshot rule:
  - Each beat carries the register value seen on port_read_data in its load cycle.
  - The register file forwards writes before reads, so a write to the same address in the load cycle appears in the beat.
  - Later writes do not alter a loaded beat.
- port_read_addr is 0 in IDLE and DRAIN.
- Reset (any time, including mid-sweep):
  - State IDLE, counter 0.
  - busy, done, out_valid = 0; out_addr, out_data, port_read_addr = 0.
  - Outputs take these values immediately; the sweep is abandoned and start is required to restart.

## Timing
- Start sampled high at edge N → busy=1 and READ after N.
- Beat 0 out_valid=1 after edge N+1.
- With out_ready held high: beat k is presented after edge N+1+k and accepted at edge N+2+k, giving one beat per cycle.
- Last beat is accepted at edge N+NUM_REGISTERS+1. After that edge: done=1, busy=0, out_valid=0.
- Total sweep is NUM_REGISTERS+2 cycles from start to done.
- Each low cycle of out_ready adds exactly one cycle.
- start=1 while done=1 (state IDLE) is accepted, so back-to-back sweeps are allowed.
- done and busy are never high together.

## Structure
- Shared package/header w0rm_core_pkg:
  - the log2 function, shared with the register file and benches;
  - the state encoding constants ST_IDLE=2'd0, ST_READ=2'd1, ST_DRAIN=2'd2.
- Natural sub-module: w0rm_util_stream_reg, a one-entry valid/ready holding register parameterised on width, instantiated at width ADDR_WIDTH+DATA_WIDTH. It exposes load_ok = !valid | ready.
- Top level holds the FSM and address counter; it connects directly to a W0RM_Core_RegisterFile read port.

## Test plan
Default parameters; registers 0..3 preloaded with 0x11, 0x22, 0x33, 0x44.
- Free-running consumer:
  - Stimulus: out_ready=1, start pulse at edge N.
  - Response: beats (0,0x11), (1,0x22), (2,0x33), (3,0x44) after edges N+1..N+4; done high only after edge N+5; busy low from then.
- Backpressure:
  - Stimulus: out_ready pattern 1,0,0,1,0,1,1,...
  - Response: the same four beats, each held stable while stalled, with no duplicates; done one cycle after acceptance of beat 3.
- Busy start:
  - Stimulus: start pulsed again at N+2.
  - Response: exactly four beats, one done.
  - Stimulus: start during the done cycle.
  - Response: a second full sweep begins immediately.
- Concurrent writes:
  - Stimulus: write reg2=0x99 in the cycle beat 2 loads.
  - Response: beat 2 carries 0x99.
  - Stimulus: write reg1=0x77 after beat 1 loads.
  - Response: beat 1 still carries 0x22.
- Non-power-of-two:
  - Stimulus: NUM_REGISTERS=5 (ADDR_WIDTH=3).
  - Response: out_addr 0..4 only, then done; the counter never reaches 5.
- Reset mid-sweep:
  - Stimulus: reset_n low while beat 1 is valid.
  - Response: out_valid, busy, out_addr, out_data immediately 0; no done.
  - Stimulus: start after release.
  - Response: the sweep restarts at address 0.
